// File: rtl/pmem_arbiter.sv
// rtl/pmem_arbiter.sv - Arbitrates the physical-memory port between I-cache and D-cache.
// One whole-line transaction at a time; registered strobes/address/wdata, combinational response routing.
module pmem_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_pmem_read,
    input  logic [ADDR_WIDTH-1:0] i_pmem_address,
    output logic [LINE_WIDTH-1:0] i_pmem_rdata,
    output logic                  i_pmem_resp,
    input  logic                  d_pmem_read,
    input  logic                  d_pmem_write,
    input  logic [ADDR_WIDTH-1:0] d_pmem_address,
    input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
    output logic [LINE_WIDTH-1:0] d_pmem_rdata,
    output logic                  d_pmem_resp,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D
    } state_t;

    state_t                  state_q, state_d;
    logic                    last_grant_q, last_grant_d;
    logic                    pmem_read_q, pmem_read_d;
    logic                    pmem_write_q, pmem_write_d;
    logic [ADDR_WIDTH-1:0]   pmem_address_q, pmem_address_d;
    logic [LINE_WIDTH-1:0]   pmem_wdata_q, pmem_wdata_d;

    logic i_req;
    logic d_req;
    logic grant_d;
    logic grant_i;

    assign i_req   = i_pmem_read;
    assign d_req   = d_pmem_read | d_pmem_write;
    // On a tie the side not granted last time wins.
    assign grant_d = d_req & (~i_req | ~last_grant_q);
    assign grant_i = i_req & ~grant_d;

    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        pmem_read_d    = pmem_read_q;
        pmem_write_d   = pmem_write_q;
        pmem_address_d = pmem_address_q;
        pmem_wdata_d   = pmem_wdata_q;
        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d        = SERVE_D;
                    last_grant_d   = 1'b1;
                    pmem_address_d = d_pmem_address;
                    pmem_wdata_d   = d_pmem_wdata;
                    // A write wins over a simultaneous (illegal) read.
                    pmem_write_d   = d_pmem_write;
                    pmem_read_d    = ~d_pmem_write;
                end else if (grant_i) begin
                    state_d        = SERVE_I;
                    last_grant_d   = 1'b0;
                    pmem_address_d = i_pmem_address;
                    pmem_read_d    = 1'b1;
                    pmem_write_d   = 1'b0;
                end
            end
            SERVE_I, SERVE_D: begin
                if (pmem_resp) begin
                    state_d      = IDLE;
                    pmem_read_d  = 1'b0;
                    pmem_write_d = 1'b0;
                end
            end
            default: begin
                state_d      = IDLE;
                pmem_read_d  = 1'b0;
                pmem_write_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            last_grant_q   <= 1'b0;
            pmem_read_q    <= 1'b0;
            pmem_write_q   <= 1'b0;
            pmem_address_q <= '0;
            pmem_wdata_q   <= '0;
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            pmem_read_q    <= pmem_read_d;
            pmem_write_q   <= pmem_write_d;
            pmem_address_q <= pmem_address_d;
            pmem_wdata_q   <= pmem_wdata_d;
        end
    end

    assign pmem_read    = pmem_read_q;
    assign pmem_write   = pmem_write_q;
    assign pmem_address = pmem_address_q;
    assign pmem_wdata   = pmem_wdata_q;

    // A response arriving while reset is applied is dropped.
    assign i_pmem_resp  = (state_q == SERVE_I) & pmem_resp & ~reset;
    assign d_pmem_resp  = (state_q == SERVE_D) & pmem_resp & ~reset;
    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;

endmodule

// File: tb/tb_pmem_arbiter.sv
// tb/tb_pmem_arbiter.sv - Self-checking bench for pmem_arbiter.
// Transaction-level reference model, random cache/memory agents and directed scenarios.
module tb_pmem_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic         i_pmem_read;
    logic [15:0]  i_pmem_address;
    logic [127:0] i_pmem_rdata;
    logic         i_pmem_resp;
    logic         d_pmem_read;
    logic         d_pmem_write;
    logic [15:0]  d_pmem_address;
    logic [127:0] d_pmem_wdata;
    logic [127:0] d_pmem_rdata;
    logic         d_pmem_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;

    always #5 clk = ~clk;

    pmem_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .i_pmem_read    (i_pmem_read),
        .i_pmem_address (i_pmem_address),
        .i_pmem_rdata   (i_pmem_rdata),
        .i_pmem_resp    (i_pmem_resp),
        .d_pmem_read    (d_pmem_read),
        .d_pmem_write   (d_pmem_write),
        .d_pmem_address (d_pmem_address),
        .d_pmem_wdata   (d_pmem_wdata),
        .d_pmem_rdata   (d_pmem_rdata),
        .d_pmem_resp    (d_pmem_resp),
        .pmem_read      (pmem_read),
        .pmem_write     (pmem_write),
        .pmem_address   (pmem_address),
        .pmem_wdata     (pmem_wdata),
        .pmem_rdata     (pmem_rdata),
        .pmem_resp      (pmem_resp)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: the transaction currently owning the memory port, if any.
    bit          m_busy = 1'b0;
    bit          m_side = 1'b0;
    bit          m_wr = 1'b0;
    bit          m_last = 1'b0;
    logic [15:0] m_addr = '0;
    logic [127:0] m_wdata = '0;

    always @(posedge clk) begin
        bit ireq, dreq, side;
        if (reset) begin
            m_busy = 0; m_side = 0; m_wr = 0; m_last = 0; m_addr = '0; m_wdata = '0;
        end else if (m_busy) begin
            if (pmem_resp) m_busy = 0;
        end else begin
            ireq = i_pmem_read;
            dreq = d_pmem_read | d_pmem_write;
            if (ireq || dreq) begin
                side   = (ireq && dreq) ? !m_last : dreq;
                m_busy = 1;
                m_side = side;
                m_last = side;
                m_wr   = side && d_pmem_write;
                m_addr = side ? d_pmem_address : i_pmem_address;
                if (side) m_wdata = d_pmem_wdata;
            end
        end
    end

    bit          i_seen = 0, d_seen = 0;
    bit          prev_strobe = 0;
    bit          log_en = 0;
    logic [15:0] obs_q[$];

    always @(negedge clk) begin
        bit exp_ir, exp_dr, strobe;
        exp_ir = m_busy && !m_side && pmem_resp && !reset;
        exp_dr = m_busy &&  m_side && pmem_resp && !reset;
        if (chk_en) begin
            chk("pmem_read", 128'(pmem_read), 128'(m_busy && !m_wr));
            chk("pmem_write", 128'(pmem_write), 128'(m_busy && m_wr));
            chk("pmem_address", 128'(pmem_address), 128'(m_addr));
            chk("pmem_wdata", pmem_wdata, m_wdata);
            chk("i_pmem_resp", 128'(i_pmem_resp), 128'(exp_ir));
            chk("d_pmem_resp", 128'(d_pmem_resp), 128'(exp_dr));
            if (exp_ir) chk("i_pmem_rdata", i_pmem_rdata, pmem_rdata);
            if (exp_dr) chk("d_pmem_rdata", d_pmem_rdata, pmem_rdata);
        end
        i_seen = i_pmem_resp;
        d_seen = d_pmem_resp;
        strobe = pmem_read | pmem_write;
        if (log_en && strobe && !prev_strobe) obs_q.push_back(pmem_address);
        prev_strobe = strobe;
    end

    bit auto_en = 0, rand_addr = 0, idle_inj = 0, rst_rand = 0;
    bit i_pend = 0, d_pend = 0;
    int req_pct = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        int r;
        tick();
        if (rst_rand) reset = ($urandom_range(0, 149) == 0);
        if (pmem_read | pmem_write) pmem_resp = ($urandom_range(0, 2) == 0);
        else pmem_resp = idle_inj && ($urandom_range(0, 7) == 0);
        pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
        if (i_pend && i_seen) begin
            i_pend = 0; i_pmem_read = 0;
        end else if (!i_pend && $urandom_range(0, 99) < req_pct) begin
            i_pend = 1; i_pmem_read = 1;
            if (rand_addr) i_pmem_address = 16'($urandom);
        end else if (rand_addr && $urandom_range(0, 3) == 0) begin
            i_pmem_address = 16'($urandom);
        end
        if (d_pend && d_seen) begin
            d_pend = 0; d_pmem_read = 0; d_pmem_write = 0;
        end else if (!d_pend && $urandom_range(0, 99) < req_pct) begin
            d_pend = 1;
            r = rand_addr ? int'($urandom_range(0, 9)) : 9;
            d_pmem_write = (r < 5);
            d_pmem_read  = (r >= 5) || (r == 0);
            if (rand_addr) d_pmem_address = 16'($urandom);
            d_pmem_wdata = {$urandom, $urandom, $urandom, $urandom};
        end else if (rand_addr && $urandom_range(0, 3) == 0) begin
            d_pmem_wdata = {$urandom, $urandom, $urandom, $urandom};
        end
    endtask

    logic [15:0] exp_ord [6];

    initial begin
        exp_ord = '{16'h2000, 16'h1000, 16'h2000, 16'h1000, 16'h2000, 16'h1000};
        reset = 1; i_pmem_read = 1; i_pmem_address = 16'h1230;
        d_pmem_read = 0; d_pmem_write = 0; d_pmem_address = '0; d_pmem_wdata = '0;
        pmem_rdata = '0; pmem_resp = 0;

        // Reset with a pending I request, then first grant on the second cycle.
        tick();
        chk_en = 1;
        tick();
        chk("rst pmem_read", 128'(pmem_read), 128'(0));
        chk("rst pmem_address", 128'(pmem_address), 128'(0));
        chk("rst i_resp", 128'(i_pmem_resp), 128'(0));
        reset = 0;
        tick();
        chk("first pmem_read", 128'(pmem_read), 128'(1));
        chk("first pmem_address", 128'(pmem_address), 128'h1230);
        pmem_resp = 1; pmem_rdata = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
        #1;
        chk("first i_resp", 128'(i_pmem_resp), 128'(1));
        chk("first i_rdata", i_pmem_rdata, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677);
        tick();
        pmem_resp = 0; i_pmem_read = 0;
        chk("first done pmem_read", 128'(pmem_read), 128'(0));

        // Lone D writeback with a 5-cycle memory.
        d_pmem_write = 1; d_pmem_address = 16'h4A00;
        d_pmem_wdata = 128'hDEAD_0000_0000_0000_0000_0000_0000_BEEF;
        tick();
        for (int k = 1; k <= 5; k++) begin
            pmem_resp = (k == 5);
            d_pmem_wdata = {$urandom, $urandom, $urandom, $urandom};
            #1;
            chk("wb pmem_write", 128'(pmem_write), 128'(1));
            chk("wb pmem_wdata", pmem_wdata, 128'hDEAD_0000_0000_0000_0000_0000_0000_BEEF);
            chk("wb d_resp", 128'(d_pmem_resp), 128'(k == 5));
            chk("wb i_resp", 128'(i_pmem_resp), 128'(0));
            tick();
        end
        pmem_resp = 0; d_pmem_write = 0;
        chk("wb done pmem_write", 128'(pmem_write), 128'(0));

        // Simultaneous first requests after reset, then address churn and idle resp.
        reset = 1;
        tick();
        reset = 0;
        i_pmem_read = 1; i_pmem_address = 16'h0100;
        d_pmem_read = 1; d_pmem_address = 16'h8000;
        tick();
        chk("tie pmem_address", 128'(pmem_address), 128'h8000);
        pmem_resp = 1;
        #1;
        chk("tie d_resp", 128'(d_pmem_resp), 128'(1));
        chk("tie i_resp", 128'(i_pmem_resp), 128'(0));
        tick();
        pmem_resp = 0; d_pmem_read = 0;
        chk("gap pmem_read", 128'(pmem_read), 128'(0));
        tick();
        chk("second pmem_read", 128'(pmem_read), 128'(1));
        chk("second pmem_address", 128'(pmem_address), 128'h0100);
        i_pmem_address = 16'h0200;
        tick();
        chk("churn pmem_address", 128'(pmem_address), 128'h0100);
        pmem_resp = 1;
        #1;
        chk("churn i_resp", 128'(i_pmem_resp), 128'(1));
        tick();
        pmem_resp = 0; i_pmem_read = 0;
        tick();
        pmem_resp = 1;
        #1;
        chk("idle i_resp", 128'(i_pmem_resp), 128'(0));
        chk("idle d_resp", 128'(d_pmem_resp), 128'(0));
        tick();
        pmem_resp = 0;

        // Alternation under continuous contention.
        i_pmem_address = 16'h1000; d_pmem_address = 16'h2000;
        obs_q.delete();
        log_en = 1; auto_en = 1; req_pct = 100;
        for (int n = 0; n < 300 && obs_q.size() < 6; n++) step();
        log_en = 0;
        chk("alt count", 128'(obs_q.size() >= 6), 128'(1));
        for (int k = 0; k < 6 && k < obs_q.size(); k++)
            chk($sformatf("alt order %0d", k), 128'(obs_q[k]), 128'(exp_ord[k]));

        // Random traffic with idle responses, illegal read+write, and random resets.
        rand_addr = 1; idle_inj = 1; rst_rand = 1; req_pct = 30;
        for (int n = 0; n < 3000; n++) step();
        rst_rand = 0; auto_en = 0;

        // Reset in the middle of a D transaction with a coincident response.
        pmem_resp = 0; i_pmem_read = 0; d_pmem_read = 0; d_pmem_write = 0;
        reset = 1;
        tick();
        reset = 0; d_pmem_read = 1; d_pmem_address = 16'h5500;
        tick();
        chk("mid pmem_read", 128'(pmem_read), 128'(1));
        reset = 1; pmem_resp = 1;
        #1;
        chk("mid d_resp", 128'(d_pmem_resp), 128'(0));
        tick();
        reset = 0; pmem_resp = 0; d_pmem_read = 0;
        chk("mid post pmem_read", 128'(pmem_read), 128'(0));
        chk("mid post pmem_write", 128'(pmem_write), 128'(0));
        i_pmem_read = 1; i_pmem_address = 16'h0300;
        tick();
        chk("mid new pmem_read", 128'(pmem_read), 128'(1));
        chk("mid new pmem_address", 128'(pmem_address), 128'h0300);
        pmem_resp = 1;
        #1;
        chk("mid new i_resp", 128'(i_pmem_resp), 128'(1));
        tick();
        i_pmem_read = 0; pmem_resp = 0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
